// File: rtl/dsp_mac_sequencer.sv
// Stream front-end for a DSP48A1 slice: issues (a,b) pairs with FIRST/ACC opcodes,
// then captures the slice's P output as one dot product per VEC_LEN samples.
module dsp_mac_sequencer #(
  parameter int VEC_LEN = 16,
  parameter int P_LAT   = 3,
  parameter int OP_SKEW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_carryin,
  output logic        dsp_rst,
  input  logic [47:0] dsp_p
);

  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_ACC   = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int WW = (P_LAT > 1) ? $clog2(P_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  // op_q[0] is aligned with dsp_a/dsp_b; the rest is the skew pipe toward OPMODE
  logic [7:0]    op_q [0:OP_SKEW];
  logic          accept;
  logic          last;
  logic          capture;

  assign accept      = in_valid && in_ready;
  assign last        = (count == CW'(VEC_LEN - 1));
  assign capture     = (state == DRAIN) && (wait_cnt == WW'(P_LAT)) && (!out_valid || out_ready);
  assign dsp_opmode  = op_q[OP_SKEW];
  assign dsp_carryin = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      dsp_rst   <= 1'b1;
      for (int i = 0; i <= OP_SKEW; i++) op_q[i] <= OP_HOLD;
    end else begin
      dsp_rst <= 1'b0;

      op_q[0] <= accept ? ((count == '0) ? OP_FIRST : OP_ACC) : OP_HOLD;
      for (int i = 1; i <= OP_SKEW; i++) op_q[i] <= op_q[i-1];

      if (accept) begin
        dsp_a <= in_a;
        dsp_b <= in_b;
        count <= last ? '0 : count + CW'(1);
      end

      case (state)
        IDLE, ACCUM: begin
          in_ready <= !(accept && last);
          if (accept) begin
            wait_cnt <= '0;
            state    <= last ? DRAIN : ACCUM;
          end
        end
        DRAIN: begin
          // Slice keeps P steady with HOLD, so a stalled capture just waits here
          if (wait_cnt != WW'(P_LAT)) wait_cnt <= wait_cnt + WW'(1);
          if (capture) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase

      if (capture) begin
        out_data  <= dsp_p;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registered, synchronous reset).
module tb_dsp_mac_sequencer;

  localparam int VEC_LEN = 4;
  localparam int P_LAT   = 3;
  localparam int OP_SKEW = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_carryin;
  logic        dsp_rst;
  logic [47:0] dsp_p;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_op [0:3] = '{8'h08, 8'h01, 8'h09, 8'h09};
  int         gap_len [0:3] = '{1, 2, 3, 0};

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .VEC_LEN (VEC_LEN),
    .P_LAT   (P_LAT),
    .OP_SKEW (OP_SKEW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_opmode  (dsp_opmode),
    .dsp_carryin (dsp_carryin),
    .dsp_rst     (dsp_rst),
    .dsp_p       (dsp_p)
  );

  // Slice model: X mux picks M on opmode[1:0]=01, Z mux picks P on opmode[3:2]=10
  logic signed [17:0] a1_reg;
  logic signed [17:0] b1_reg;
  logic signed [35:0] m_reg;
  logic [7:0]         op_reg;
  logic signed [47:0] p_reg;
  logic signed [47:0] x_mux;
  logic signed [47:0] z_mux;

  always_comb begin
    x_mux = '0;
    z_mux = '0;
    if (op_reg[1:0] == 2'b01) x_mux = {{12{m_reg[35]}}, m_reg};
    if (op_reg[3:2] == 2'b10) z_mux = p_reg;
  end

  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      a1_reg <= '0;
      b1_reg <= '0;
      m_reg  <= '0;
      op_reg <= '0;
      p_reg  <= '0;
    end else begin
      a1_reg <= dsp_a;
      b1_reg <= dsp_b;
      m_reg  <= a1_reg * b1_reg;
      op_reg <= dsp_opmode;
      p_reg  <= z_mux + x_mux;
    end
  end

  assign dsp_p = p_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic applyStimulus(input int a, input int b);
    int n;
    n = 0;
    in_a     = 18'(a);
    in_b     = 18'(b);
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    checkOutput("accept_wait", {47'd0, in_ready}, 48'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input logic [47:0] exp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, {47'd0, out_valid}, 48'd1);
    checkOutput(tag, out_data, exp);
    tick();
    checkOutput({tag, "_taken"}, {47'd0, out_valid}, 48'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state and release
    repeat (3) tick();
    checkOutput("rst_in_ready",   {47'd0, in_ready},    48'd0);
    checkOutput("rst_out_valid",  {47'd0, out_valid},   48'd0);
    checkOutput("rst_out_data",   out_data,             48'd0);
    checkOutput("rst_dsp_a",      {30'd0, dsp_a},       48'd0);
    checkOutput("rst_dsp_b",      {30'd0, dsp_b},       48'd0);
    checkOutput("rst_opmode",     {40'd0, dsp_opmode},  48'h08);
    checkOutput("rst_dsp_rst",    {47'd0, dsp_rst},     48'd1);
    checkOutput("rst_carryin",    {47'd0, dsp_carryin}, 48'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_dsp_rst_hold", {47'd0, dsp_rst},  48'd1);
    checkOutput("rel_in_ready_low", {47'd0, in_ready}, 48'd0);
    tick();
    checkOutput("rel_dsp_rst_fall", {47'd0, dsp_rst},  48'd0);
    checkOutput("rel_in_ready",     {47'd0, in_ready}, 48'd1);

    // Back-to-back vector 1..4 . 5..8 = 70, opcode sequence and latency
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 18'(i + 1);
      in_b = 18'(i + 5);
      tick();
      checkOutput("b2b_dsp_a",  {30'd0, dsp_a},      48'(i + 1));
      checkOutput("b2b_opmode", {40'd0, dsp_opmode}, {40'd0, exp_op[i]});
    end
    in_valid = 1'b0;
    checkOutput("drain_in_ready", {47'd0, in_ready}, 48'd0);
    tick();
    checkOutput("b2b_opmode_last", {40'd0, dsp_opmode}, 48'h09);
    tick();
    checkOutput("b2b_opmode_hold", {40'd0, dsp_opmode}, 48'h08);
    tick();
    checkOutput("lat_edge3_valid", {47'd0, out_valid}, 48'd0);
    tick();
    checkOutput("lat_edge4_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("b2b_sum",         out_data,           48'd70);
    checkOutput("idle_in_ready",   {47'd0, in_ready},  48'd1);
    tick();
    checkOutput("b2b_taken",       {47'd0, out_valid}, 48'd0);

    // Signed products
    repeat (4) applyStimulus(-3, 7);
    waitResult(-48'sd84, "signed_neg");
    repeat (4) applyStimulus(-131072, -131072);
    waitResult(48'h10_0000_0000, "signed_max");

    // Idle gaps inside a vector
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i + 1, i + 5);
      checkOutput("gap_hold_pre", {40'd0, dsp_opmode}, 48'h08);
      for (int j = 1; j <= gap_len[i]; j++) begin
        tick();
        checkOutput("gap_dsp_a_held", {30'd0, dsp_a}, 48'(i + 1));
        if (j == 1) checkOutput("gap_sample_op", {40'd0, dsp_opmode}, (i == 0) ? 48'h01 : 48'h09);
        else        checkOutput("gap_hold",      {40'd0, dsp_opmode}, 48'h08);
      end
    end
    waitResult(48'd70, "gap_sum");

    // Output stall across two vectors
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i + 1, i + 5);
    repeat (4) applyStimulus(1, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("stall_in_ready", {47'd0, in_ready},  48'd0);
      checkOutput("stall_valid",    {47'd0, out_valid}, 48'd1);
      checkOutput("stall_data",     out_data,           48'd70);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("stall_next_valid", {47'd0, out_valid}, 48'd1);
    checkOutput("stall_next_data",  out_data,           48'd4);
    checkOutput("stall_in_ready_back", {47'd0, in_ready}, 48'd1);
    tick();
    checkOutput("stall_next_taken", {47'd0, out_valid}, 48'd0);
    seen = 0;
    repeat (6) begin
      tick();
      seen = seen | int'(out_valid);
    end
    checkOutput("stall_no_dup", 48'(seen), 48'd0);

    // Reset in the middle of a vector
    applyStimulus(3, 3);
    applyStimulus(3, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {47'd0, in_ready}, 48'd0);
    checkOutput("midrst_dsp_rst",  {47'd0, dsp_rst},  48'd1);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_rel_dsp_rst",  {47'd0, dsp_rst},  48'd0);
    checkOutput("midrst_rel_in_ready", {47'd0, in_ready}, 48'd1);
    seen = 0;
    repeat (8) begin
      tick();
      seen = seen | int'(out_valid);
    end
    checkOutput("midrst_no_valid", 48'(seen), 48'd0);
    repeat (4) applyStimulus(2, 2);
    waitResult(48'd16, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
